// File: rtl/stage_sequencer.sv
// Stage sequencer: loads program words over a valid/ready stream, then rotates
// FETCH -> DECODE -> EXECUTE until a reload request returns it to LOAD.
module stage_sequencer #(
  parameter int unsigned INSTR_W    = 12,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned PROG_DEPTH = 256
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic                i_Load_valid,
  input  logic [INSTR_W-1:0]  i_Load_data,
  input  logic                i_Load_last,
  output logic                o_Load_ready,
  input  logic                i_Reload,
  output logic [1:0]          o_Stage,
  output logic [ADDR_W-1:0]   o_Pmem_addr,
  output logic [INSTR_W-1:0]  o_Pmem_wdata,
  output logic                o_Pmem_we,
  output logic [ADDR_W:0]     o_Prog_len,
  output logic                o_Load_ovf
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [2:0] ST_ACCEPT  = 3'd0;
  localparam logic [2:0] ST_DRAIN   = 3'd1;
  localparam logic [2:0] ST_FETCH   = 3'd2;
  localparam logic [2:0] ST_DECODE  = 3'd3;
  localparam logic [2:0] ST_EXECUTE = 3'd4;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PROG_DEPTH - 1);

  logic [2:0]         state_q,      state_d;
  logic [1:0]         stage_q,      stage_d;
  logic               load_ready_q, load_ready_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;
  logic [ADDR_W-1:0]  pmem_addr_q,  pmem_addr_d;
  logic [INSTR_W-1:0] pmem_wdata_q, pmem_wdata_d;
  logic               pmem_we_q,    pmem_we_d;
  logic [CNT_W-1:0]   prog_len_q,   prog_len_d;
  logic               load_ovf_q,   load_ovf_d;
  logic               xfer;

  // Ready is only ever high in ACCEPT, so this is the full handshake.
  assign xfer = i_Load_valid & load_ready_q;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q      <= ST_ACCEPT;
      stage_q      <= 2'b00;
      load_ready_q <= 1'b0;
      cnt_q        <= '0;
      pmem_addr_q  <= '0;
      pmem_wdata_q <= '0;
      pmem_we_q    <= 1'b0;
      prog_len_q   <= '0;
      load_ovf_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      load_ready_q <= load_ready_d;
      cnt_q        <= cnt_d;
      pmem_addr_q  <= pmem_addr_d;
      pmem_wdata_q <= pmem_wdata_d;
      pmem_we_q    <= pmem_we_d;
      prog_len_q   <= prog_len_d;
      load_ovf_q   <= load_ovf_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pmem_addr_d  = pmem_addr_q;
    pmem_wdata_d = pmem_wdata_q;
    pmem_we_d    = 1'b0;
    prog_len_d   = prog_len_q;
    load_ovf_d   = load_ovf_q;
    stage_d      = 2'b00;

    case (state_q)
      ST_ACCEPT: begin
        if (xfer) begin
          pmem_we_d    = 1'b1;
          pmem_addr_d  = cnt_q[ADDR_W-1:0];
          pmem_wdata_d = i_Load_data;
          cnt_d        = cnt_q + CNT_W'(1);
          // A word that fills the last slot ends the load just like last=1.
          if (i_Load_last || (cnt_q == LAST_IDX)) begin
            state_d    = ST_DRAIN;
            prog_len_d = cnt_q + CNT_W'(1);
            load_ovf_d = ~i_Load_last;
          end
        end
      end
      ST_DRAIN:  state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        if (i_Reload) begin
          state_d    = ST_ACCEPT;
          cnt_d      = '0;
          load_ovf_d = 1'b0;
        end else begin
          state_d    = ST_FETCH;
        end
      end
      default:   state_d = ST_ACCEPT;
    endcase

    case (state_d)
      ST_FETCH:   stage_d = 2'b01;
      ST_DECODE:  stage_d = 2'b10;
      ST_EXECUTE: stage_d = 2'b11;
      default:    stage_d = 2'b00;
    endcase

    load_ready_d = (state_d == ST_ACCEPT);
  end

  assign o_Load_ready = load_ready_q;
  assign o_Stage      = stage_q;
  assign o_Pmem_addr  = pmem_addr_q;
  assign o_Pmem_wdata = pmem_wdata_q;
  assign o_Pmem_we    = pmem_we_q;
  assign o_Prog_len   = prog_len_q;
  assign o_Load_ovf   = load_ovf_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: directed scenarios plus random traffic, all checked
// every cycle against a behavioural model of the load/run protocol.
module tb_stage_sequencer;

  localparam int unsigned IW    = 12;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          valid;
  logic [IW-1:0] data;
  logic          last;
  logic          ready;
  logic          reload;
  logic [1:0]    stage;
  logic [AW-1:0] paddr;
  logic [IW-1:0] pwdata;
  logic          pwe;
  logic [AW:0]   plen;
  logic          povf;

  stage_sequencer #(.INSTR_W(IW), .ADDR_W(AW), .PROG_DEPTH(DEPTH)) dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_Load_valid (valid),
    .i_Load_data  (data),
    .i_Load_last  (last),
    .o_Load_ready (ready),
    .i_Reload     (reload),
    .o_Stage      (stage),
    .o_Pmem_addr  (paddr),
    .o_Pmem_wdata (pwdata),
    .o_Pmem_we    (pwe),
    .o_Prog_len   (plen),
    .o_Load_ovf   (povf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = loading, 1 = final write draining, 2 = running.
  int m_mode = 0, m_phase = 0, m_cnt = 0;
  int e_ready = 0, e_stage = 0, e_addr = 0, e_wdata = 0, e_we = 0, e_len = 0, e_ovf = 0;

  task automatic model_step();
    if (!rst_n) begin
      m_mode = 0; m_phase = 0; m_cnt = 0;
      e_ready = 0; e_stage = 0; e_addr = 0; e_wdata = 0; e_we = 0; e_len = 0; e_ovf = 0;
    end else begin
      e_we = 0;
      if (m_mode == 0) begin
        if (valid && e_ready != 0) begin
          e_we = 1; e_addr = m_cnt; e_wdata = int'(data);
          m_cnt++;
          if (last || m_cnt == DEPTH) begin
            m_mode = 1; e_len = m_cnt; e_ovf = last ? 0 : 1;
          end
        end
      end else if (m_mode == 1) begin
        m_mode = 2; m_phase = 0;
      end else begin
        if (m_phase == 2 && reload) begin
          m_mode = 0; m_cnt = 0; e_ovf = 0;
        end else begin
          m_phase = (m_phase + 1) % 3;
        end
      end
      e_ready = (m_mode == 0) ? 1 : 0;
      e_stage = (m_mode == 2) ? m_phase + 1 : 0;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    chk("stage", 32'(stage),  e_stage);
    chk("ready", 32'(ready),  e_ready);
    chk("we",    32'(pwe),    e_we);
    chk("addr",  32'(paddr),  e_addr);
    chk("wdata", 32'(pwdata), e_wdata);
    chk("len",   32'(plen),   e_len);
    chk("ovf",   32'(povf),   e_ovf);
  end

  // Log of observed writes for the directed literal checks.
  int wa[$];
  int wd[$];
  int wc[$];
  always @(negedge clk) begin
    if (pwe === 1'b1) begin
      wa.push_back(int'(paddr));
      wd.push_back(int'(pwdata));
      wc.push_back(cyc);
    end
  end

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete();
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic send(input logic [IW-1:0] d, input logic l, input int bound, output bit ok);
    logic rdy;
    ok = 1'b0;
    valid = 1'b1; data = d; last = l;
    for (int i = 0; i < bound; i++) begin
      rdy = ready;
      @(negedge clk); #1;
      if (rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    valid = 1'b0; data = IW'($urandom); last = 1'($urandom);
  endtask

  task automatic wait_stage(input int s, input int bound);
    int n = 0;
    while (stage !== 2'(s) && n < bound) begin
      @(negedge clk); #1;
      n++;
    end
    if (stage !== 2'(s)) chk("wait_stage_timeout", 32'(stage), 32'(s));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int nacc;
    int ed[3];
    rst_n = 1'b0; valid = 1'b0; data = '0; last = 1'b0; reload = 1'b0;
    ed = '{'h2A5, 'h811, 'h100};
    repeat (2) @(negedge clk);
    #1;

    // Reset values
    chk("rst_stage", 32'(stage), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_we",    32'(pwe),   0);
    chk("rst_len",   32'(plen),  0);
    chk("rst_ovf",   32'(povf),  0);
    chk("rst_addr",  32'(paddr), 0);
    rst_n = 1'b1;
    chk("ready_before_edge", 32'(ready), 0);
    @(negedge clk); #1;
    chk("ready_after_edge", 32'(ready), 1);

    // Basic load, valid held high
    clear_log();
    send(12'h2A5, 1'b0, 4, ok); chk("basic_acc0", 32'(ok), 1);
    send(12'h811, 1'b0, 4, ok); chk("basic_acc1", 32'(ok), 1);
    send(12'h100, 1'b1, 4, ok); chk("basic_acc2", 32'(ok), 1);
    chk("drain_stage", 32'(stage), 0);
    chk("drain_ready", 32'(ready), 0);
    chk("drain_we",    32'(pwe),   1);
    idle(1); chk("rot_fetch",   32'(stage), 1);
    idle(1); chk("rot_decode",  32'(stage), 2);
    idle(1); chk("rot_execute", 32'(stage), 3);
    idle(1); chk("rot_wrap",    32'(stage), 1);
    chk("basic_len", 32'(plen), 3);
    chk("basic_ovf", 32'(povf), 0);
    chk("basic_nwr", 32'(wa.size()), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < wa.size()) begin
        chk("basic_waddr", 32'(wa[i]), 32'(i));
        chk("basic_wdata", 32'(wd[i]), 32'(ed[i]));
        if (i > 0) chk("basic_wgap", 32'(wc[i] - wc[i-1]), 1);
      end
    end

    // Reload raised in DECODE and held
    wait_stage(2, 6);
    reload = 1'b1;
    wait_stage(0, 6);
    reload = 1'b0;
    chk("reload_ready", 32'(ready), 1);
    chk("reload_ovf",   32'(povf),  0);

    // Gapped load
    clear_log();
    send(12'h0F1, 1'b0, 4, ok); idle(1);
    send(12'h0F2, 1'b0, 4, ok); idle(1);
    send(12'h0F3, 1'b1, 4, ok);
    chk("gap_nwr", 32'(wa.size()), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < wa.size()) begin
        chk("gap_waddr", 32'(wa[i]), 32'(i));
        if (i > 0) chk("gap_wgap", 32'(wc[i] - wc[i-1]), 2);
      end
    end
    chk("gap_len", 32'(plen), 3);

    // Reload pulse only in FETCH is ignored
    wait_stage(1, 6);
    reload = 1'b1;
    @(negedge clk); #1;
    reload = 1'b0;
    chk("pulse_decode", 32'(stage), 2);
    idle(1); chk("pulse_execute", 32'(stage), 3);
    idle(1); chk("pulse_no_reload", 32'(stage), 1);

    // Overflow: six words, last never set
    wait_stage(2, 6);
    reload = 1'b1;
    wait_stage(0, 6);
    reload = 1'b0;
    clear_log();
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      send(12'(16 * i + 3), 1'b0, 3, ok);
      nacc += int'(ok);
    end
    chk("ovf_accepted", 32'(nacc), 4);
    chk("ovf_nwr", 32'(wa.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wa.size()) chk("ovf_waddr", 32'(wa[i]), 32'(i));
    end
    chk("ovf_flag", 32'(povf), 1);
    chk("ovf_len",  32'(plen), 4);

    // Reload clears overflow, length held
    wait_stage(2, 6);
    reload = 1'b1;
    wait_stage(0, 6);
    reload = 1'b0;
    chk("ovf_cleared", 32'(povf), 0);
    chk("len_held",    32'(plen), 4);

    // Async reset right after the second accepted word
    send(12'hABC, 1'b0, 4, ok);
    send(12'h123, 1'b0, 4, ok);
    chk("pre_rst_we", 32'(pwe), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_we",    32'(pwe),   0);
    chk("async_stage", 32'(stage), 0);
    chk("async_addr",  32'(paddr), 0);
    chk("async_ready", 32'(ready), 0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Single-word program after reset
    clear_log();
    send(12'h000, 1'b1, 4, ok);
    chk("single_acc",  32'(ok), 1);
    chk("single_nwr",  32'(wa.size()), 1);
    if (wa.size() > 0) chk("single_waddr", 32'(wa[0]), 0);
    chk("single_len",  32'(plen), 1);
    chk("single_drain", 32'(stage), 0);
    idle(1); chk("single_fetch", 32'(stage), 1);

    // Random traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 249) == 0) rst_n = 1'b0;
      valid  = 1'($urandom_range(0, 1));
      data   = IW'($urandom);
      last   = ($urandom_range(0, 3) == 0);
      reload = ($urandom_range(0, 2) == 0);
      @(negedge clk); #1;
    end
    rst_n = 1'b1;
    reload = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
